intt_4_seq: RTL and testbench

Sequential 4-point inverse NTT over Z_q, q = 257, psi = 64. It is the inverse of the combinational 4-point forward NTT, so a forward-transformed word passed through this block returns the original coefficients, with the n^-1 scaling included. The block sits on the receive side of the polynomial-multiply datapath. It uses one shared Gentleman-Sande butterfly over four cycles and has valid/ready handshakes on both sides.

---
 rtl/ntt_pkg.sv | 37 +++
 rtl/intt_bf.sv | 35 +++
 rtl/intt_4_seq.sv | 122 ++++++++++++
 tb/tb_intt_4_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and mod-257 reduction for the NTT datapath.
// The twiddle constants and the fold below are only valid for q = 257.
package ntt_pkg;

   localparam int Q    = 257;
   localparam int NPTS = 4;
   localparam int W    = 9;

   localparam logic [W-1:0] INV_PSI        = 9'd253;
   localparam logic [W-1:0] INV_PSI3       = 9'd193;
   localparam logic [W-1:0] N_INV          = 9'd193;
   localparam logic [W-1:0] INV_PSI2_N_INV = 9'd4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      BF0  = 3'd1,
      BF1  = 3'd2,
      BF2  = 3'd3,
      BF3  = 3'd4,
      DONE = 3'd5
   } intt_state_t;

   // 2^8 == -1 (mod 257), so p = h*2^16 + m*2^8 + l folds to l - m + h.
   // The folded value lies in -255..258 and needs one correction either way.
   function automatic logic [W-1:0] mod_q_fold(input logic [2*W-1:0] p);
      logic signed [W+1:0] t;
      t = $signed({3'b000, p[7:0]}) - $signed({3'b000, p[15:8]})
        + $signed({9'b0_0000_0000, p[17:16]});
      if (t < 0) begin
         t = t + 11'sd257;
      end else if (t >= 11'sd257) begin
         t = t - 11'sd257;
      end
      return W'(t);
   endfunction

endpackage

// File: rtl/intt_bf.sv
// Gentleman-Sande butterfly over Z_257: s = (x+y)*c0, d = (x-y)*c1, both canonical.
// Purely combinational so it can be time-shared by any INTT size.
module intt_bf
   import ntt_pkg::*;
(
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] c0,
   input  logic [W-1:0] c1,
   output logic [W-1:0] s,
   output logic [W-1:0] d
);

   localparam logic [W:0] Q_X = (W+1)'(Q);

   logic [W:0]     sum_raw;
   logic [W:0]     dif_raw;
   logic [W:0]     sum_c;
   logic [W:0]     dif_c;
   logic [2*W-1:0] prod_s;
   logic [2*W-1:0] prod_d;

   always_comb begin
      sum_raw = {1'b0, x} + {1'b0, y};
      // Bias by q so the difference never goes negative.
      dif_raw = {1'b0, x} + Q_X - {1'b0, y};
      sum_c   = (sum_raw >= Q_X) ? sum_raw - Q_X : sum_raw;
      dif_c   = (dif_raw >= Q_X) ? dif_raw - Q_X : dif_raw;
      prod_s  = {{W{1'b0}}, W'(sum_c)} * {{W{1'b0}}, c0};
      prod_d  = {{W{1'b0}}, W'(dif_c)} * {{W{1'b0}}, c1};
      s       = mod_q_fold(prod_s);
      d       = mod_q_fold(prod_d);
   end

endmodule

// File: rtl/intt_4_seq.sv
// Sequential 4-point inverse NTT mod 257, one shared GS butterfly over four cycles.
//
//   state | meaning
//   IDLE  | in_ready=1, capture and canonicalise an on in_valid
//   BF0   | (r0,r1) with c0=1,     c1=psi^-1
//   BF1   | (r2,r3) with c0=1,     c1=psi^-3
//   BF2   | (r0,r2) with c0=n^-1,  c1=psi^-2*n^-1
//   BF3   | (r1,r3) with c0=n^-1,  c1=psi^-2*n^-1
//   DONE  | out_valid=1, a held until out_ready
module intt_4_seq #(
   parameter int N = 9,
   parameter int Q = 257
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [4*N-1:0] an,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [4*N-1:0] a,
   output logic           out_valid,
   input  logic           out_ready
);
   import ntt_pkg::*;

   localparam logic [N-1:0] Q_N = N'(Q);

   intt_state_t  state;
   intt_state_t  state_nxt;
   logic [N-1:0] r [NPTS];

   logic [N-1:0] bf_x;
   logic [N-1:0] bf_y;
   logic [N-1:0] bf_c0;
   logic [N-1:0] bf_c1;
   logic [N-1:0] bf_s;
   logic [N-1:0] bf_d;

   function automatic logic [N-1:0] canon(input logic [N-1:0] c);
      return (c >= Q_N) ? c - Q_N : c;
   endfunction

   intt_bf u_bf (
      .x  (bf_x),
      .y  (bf_y),
      .c0 (bf_c0),
      .c1 (bf_c1),
      .s  (bf_s),
      .d  (bf_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         for (int i = 0; i < NPTS; i++) r[i] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < NPTS; i++) r[i] <= canon(an[N*i +: N]);
               end
            end
            BF0: begin
               r[0] <= bf_s;
               r[1] <= bf_d;
            end
            BF1: begin
               r[2] <= bf_s;
               r[3] <= bf_d;
            end
            BF2: begin
               r[0] <= bf_s;
               r[2] <= bf_d;
            end
            BF3: begin
               r[1] <= bf_s;
               r[3] <= bf_d;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      bf_x      = r[0];
      bf_y      = r[1];
      bf_c0     = N'(1);
      bf_c1     = INV_PSI;
      case (state)
         IDLE: if (in_valid) state_nxt = BF0;
         BF0:  state_nxt = BF1;
         BF1: begin
            bf_x      = r[2];
            bf_y      = r[3];
            bf_c1     = INV_PSI3;
            state_nxt = BF2;
         end
         BF2: begin
            bf_x      = r[0];
            bf_y      = r[2];
            bf_c0     = N_INV;
            bf_c1     = INV_PSI2_N_INV;
            state_nxt = BF3;
         end
         BF3: begin
            bf_x      = r[1];
            bf_y      = r[3];
            bf_c0     = N_INV;
            bf_c1     = INV_PSI2_N_INV;
            state_nxt = DONE;
         end
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign a         = {r[3], r[2], r[1], r[0]};

endmodule

// File: tb/tb_intt_4_seq.sv
// Self-checking bench for intt_4_seq: directed vectors, forward-NTT round trips,
// backpressure, mid-transform reset and throughput, with a scoreboard on the output.
module tb_intt_4_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [35:0] an;
   logic        in_valid;
   logic        in_ready;
   logic [35:0] a;
   logic        out_valid;
   logic        out_ready;

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   logic [35:0] sb [$];

   intt_4_seq #(.N(9), .Q(257)) dut (
      .clk       (clk),
      .rst       (rst),
      .an        (an),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every output transfer pops the oldest expected word.
   always @(negedge clk) begin
      logic [35:0] exp_w;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected: got a=%h with no transform pending", a);
         end else begin
            exp_w = sb.pop_front();
            if (a !== exp_w) begin
               errors++;
               $display("FAIL scoreboard_data: got a=%h expected %h", a, exp_w);
            end
         end
      end
   end

   function automatic logic [35:0] pk(input int c0, input int c1, input int c2, input int c3);
      return {9'(c3), 9'(c2), 9'(c1), 9'(c0)};
   endfunction

   function automatic int md(input int x);
      return ((x % 257) + 257) % 257;
   endfunction

   // Negacyclic forward NTT (Cooley-Tukey, psi = 64), bit-reversed output order.
   function automatic logic [35:0] fwd(input logic [35:0] t);
      int c [4];
      int n0, n1, n2, n3, u;
      for (int i = 0; i < 4; i++) c[i] = int'(t[9*i +: 9]);
      u  = md(c[2] * 241);
      n0 = md(c[0] + u);
      n2 = md(c[0] - u);
      u  = md(c[3] * 241);
      n1 = md(c[1] + u);
      n3 = md(c[1] - u);
      u  = md(n1 * 64);
      c[0] = md(n0 + u);
      c[1] = md(n0 - u);
      u  = md(n3 * 4);
      c[2] = md(n2 + u);
      c[3] = md(n2 - u);
      return pk(c[0], c[1], c[2], c[3]);
   endfunction

   task automatic send(input logic [35:0] v, input logic [35:0] exp_w, output int acc);
      int n;
      n   = 0;
      acc = -1;
      @(posedge clk); #1;
      an       = v;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(exp_w);
            acc = cyc;
            break;
         end
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) break;
         n++;
         if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout: %0d results pending, required 0", tag, sb.size());
            sb.delete();
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; an = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
      checks++;
      if (a !== 36'h0) begin errors++; $display("FAIL reset_a: got %h required 0", a); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready); end
   endtask

   task automatic test_delta();
      int acc, first_ov;
      first_ov = -1;
      send(pk(1, 1, 1, 1), pk(1, 0, 0, 0), acc);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (out_valid) begin first_ov = cyc; break; end
      end
      checks++;
      if (first_ov - acc !== 5) begin
         errors++;
         $display("FAIL delta_latency: out_valid after %0d cycles, required 5", first_ov - acc);
      end
      wait_drain("delta");
   endtask

   task automatic test_directed();
      int acc;
      send(pk(64, 193, 4, 253), pk(0, 1, 0, 0), acc);
      wait_drain("shifted_delta");
      send(pk(204, 83, 172, 51), pk(256, 256, 256, 256), acc);
      wait_drain("max_coeff");
   endtask

   task automatic test_noncanonical();
      int acc;
      send(pk(258, 258, 258, 258), pk(1, 0, 0, 0), acc);
      send(pk(511, 511, 511, 511), pk(254, 0, 0, 0), acc);
      send(pk(257, 257, 257, 257), pk(0, 0, 0, 0), acc);
      wait_drain("noncanonical");
   endtask

   task automatic test_round_trip();
      int          acc;
      logic [35:0] orig, v;
      logic [8:0]  cf;
      for (int k = 0; k < 1000; k++) begin
         orig = pk($urandom_range(0, 256), $urandom_range(0, 256),
                   $urandom_range(0, 256), $urandom_range(0, 256));
         v = fwd(orig);
         for (int i = 0; i < 4; i++) begin
            cf = v[9*i +: 9];
            if (cf <= 9'd254 && ($urandom_range(0, 3) == 0 || k % 8 == 0)) v[9*i +: 9] = cf + 9'd257;
         end
         send(v, orig, acc);
      end
      wait_drain("round_trip");
   endtask

   task automatic test_backpressure();
      int          acc, n;
      logic [35:0] held;
      out_ready = 1'b0;
      send(pk(64, 193, 4, 253), pk(0, 1, 0, 0), acc);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %0b required 1", out_valid); end
      held = a;
      @(posedge clk); #1;
      an = pk(1, 1, 1, 1);
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (a !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold_%0d: a=%h in_ready=%0b out_valid=%0b, required a=%h in_ready=0 out_valid=1",
                     k, a, in_ready, out_valid, held);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: in_ready=%0b out_valid=%0b, required 1 and 0", in_ready, out_valid);
      end
      n = 0;
      for (int k = 0; k < 8; k++) begin @(negedge clk); if (out_valid) n++; end
      checks++;
      if (n !== 0) begin errors++; $display("FAIL bp_no_phantom: out_valid seen %0d cycles, required 0", n); end
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL bp_one_transfer: %0d pending, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_reset_mid();
      int acc, n;
      send(pk(204, 83, 172, 51), pk(256, 256, 256, 256), acc);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %0b required 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %0b required 0", out_valid); end
      checks++;
      if (a !== 36'h0) begin errors++; $display("FAIL rstmid_a: got %h required 0", a); end
      n = 0;
      for (int k = 0; k < 8; k++) begin @(negedge clk); if (out_valid) n++; end
      checks++;
      if (n !== 0) begin errors++; $display("FAIL rstmid_aborted: out_valid seen %0d cycles, required 0", n); end
      send(pk(1, 1, 1, 1), pk(1, 0, 0, 0), acc);
      wait_drain("rstmid_next");
   endtask

   task automatic test_back_to_back();
      int a1, a2, a3;
      out_ready = 1'b1;
      send(pk(1, 1, 1, 1), pk(1, 0, 0, 0), a1);
      send(pk(64, 193, 4, 253), pk(0, 1, 0, 0), a2);
      send(pk(204, 83, 172, 51), pk(256, 256, 256, 256), a3);
      checks++;
      if (a2 - a1 !== 6) begin errors++; $display("FAIL b2b_gap_1: got %0d cycles required 6", a2 - a1); end
      checks++;
      if (a3 - a2 !== 6) begin errors++; $display("FAIL b2b_gap_2: got %0d cycles required 6", a3 - a2); end
      wait_drain("b2b");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_delta();
      test_directed();
      test_noncanonical();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_round_trip();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
